// File: rtl/cla_add_sched_if.sv
// Request/result bundle for the nibble-serial add/sub scheduler.
// Two requesters on one side, one result consumer on the other.
interface cla_add_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         res_id;

  // Block side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output res_valid, res_sum, res_cout, res_ovf, res_id,
    input  res_ready
  );

  // Requester/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  res_valid, res_sum, res_cout, res_ovf, res_id,
    output res_ready
  );
endinterface

// File: rtl/cla_add_sched.sv
// Two-requester add/sub unit that time-shares a single 4-bit
// carry-lookahead nibble adder, walking the operands LSB nibble first.
// Round-robin arbitration in IDLE, NIBBLES cycles of RUN, then the result
// is held in DONE until the consumer takes it.
module cla_add_sched #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  cla_add_sched_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;        // already inverted for subtract
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic [KW-1:0] r_k;
  logic          r_id;
  logic          r_last;     // requester granted most recently

  // Arbitration: a lone valid wins; on a tie the one not granted last wins.
  logic w_gnt0, w_gnt1, w_idle, w_acc0, w_acc1;
  assign w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last);
  // Readys are held low while reset is asserted so nothing looks accepted.
  assign w_idle = (r_state == IDLE) & rst_n;
  assign bus.req0_ready = w_idle & w_gnt0;
  assign bus.req1_ready = w_idle & w_gnt1;
  assign w_acc0 = bus.req0_ready;   // ready implies valid
  assign w_acc1 = bus.req1_ready;

  // Operand mux for the accepted requester.
  logic [W-1:0] w_in_a, w_in_b;
  logic         w_in_sub;
  assign w_in_a   = w_acc1 ? bus.req1_a   : bus.req0_a;
  assign w_in_b   = w_acc1 ? bus.req1_b   : bus.req0_b;
  assign w_in_sub = w_acc1 ? bus.req1_sub : bus.req0_sub;

  // Current nibble slice.
  logic [KW+1:0] w_base;
  logic [3:0]    w_na, w_nb, w_g, w_p, w_ns;
  logic [4:0]    w_c;
  assign w_base = {r_k, 2'b00};
  assign w_na   = r_a[w_base +: 4];
  assign w_nb   = r_b[w_base +: 4];

  // 4-bit carry-lookahead: every carry is a flat sum of generate/propagate
  // products so no carry ripples through a previous bit's result.
  assign w_g    = w_na & w_nb;
  assign w_p    = w_na ^ w_nb;
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_ns   = w_p ^ w_c[3:0];

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc0 | w_acc1) begin
            r_a     <= w_in_a;
            r_b     <= w_in_sub ? ~w_in_b : w_in_b;
            r_carry <= w_in_sub;             // +1 completes two's complement
            r_k     <= '0;
            r_id    <= w_acc1;
            r_last  <= w_acc1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: 4] <= w_ns;
          r_carry            <= w_c[4];
          r_k                <= r_k + 1'b1;
          if (r_k == KW'(NIBBLES - 1)) r_state <= DONE;
        end
        DONE: begin
          if (bus.res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result outputs read zero unless a result is being presented.
  logic w_done;
  assign w_done        = (r_state == DONE);
  assign bus.res_valid = w_done;
  assign bus.res_sum   = w_done ? r_sum : '0;
  assign bus.res_cout  = w_done & r_carry;
  assign bus.res_ovf   = w_done & (r_a[W-1] == r_b[W-1]) & (r_sum[W-1] != r_a[W-1]);
  assign bus.res_id    = w_done & r_id;
endmodule

// File: tb/tb_cla_add_sched.sv
// Directed bench for cla_add_sched with a transaction-level reference model
// checked every cycle, plus literal expectations for the key vectors.
module tb_cla_add_sched;
  localparam int NIBBLES = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_add_sched_if #(.NIBBLES(NIBBLES)) bus();
  cla_add_sched #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from signed/unsigned integer ranges: {ovf, cout, sum}.
  function automatic logic [W+1:0] model_res(input logic [W-1:0] a, b, input logic sub);
    int sa, sb, sr;
    logic cout, ovf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      sr   = sa - sb;
      cout = (a >= b);                        // no borrow
    end else begin
      sr   = sa + sb;
      cout = (32'(a) + 32'(b)) > 32'hFFFF;
    end
    ovf = (sr > 32767) || (sr < -32768);
    return {ovf, cout, 16'(sr)};
  endfunction

  // Model: idle / busy for NIBBLES cycles / holding a result.
  logic         m_busy, m_done, m_last, m_id, m_cout, m_ovf;
  int           m_cnt;
  logic [W-1:0] m_sum;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_last <= 1'b1; m_cnt <= 0;
      m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_id <= 1'b0;
    end else if (m_done) begin
      if (bus.res_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin m_busy <= 1'b0; m_done <= 1'b1; end
    end else if (bus.req0_valid && (!bus.req1_valid || m_last)) begin
      {m_ovf, m_cout, m_sum} <= model_res(bus.req0_a, bus.req0_b, bus.req0_sub);
      m_id <= 1'b0; m_last <= 1'b0; m_busy <= 1'b1; m_cnt <= NIBBLES;
    end else if (bus.req1_valid) begin
      {m_ovf, m_cout, m_sum} <= model_res(bus.req1_a, bus.req1_b, bus.req1_sub);
      m_id <= 1'b1; m_last <= 1'b1; m_busy <= 1'b1; m_cnt <= NIBBLES;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req0_ready", 32'(bus.req0_ready), 32'(!m_busy && !m_done && rst_n &&
          bus.req0_valid && (!bus.req1_valid || m_last)));
      chk("req1_ready", 32'(bus.req1_ready), 32'(!m_busy && !m_done && rst_n &&
          bus.req1_valid && (!bus.req0_valid || !m_last)));
      chk("res_valid", 32'(bus.res_valid), 32'(m_done));
      chk("res_sum",   32'(bus.res_sum),   m_done ? 32'(m_sum)  : 32'd0);
      chk("res_cout",  32'(bus.res_cout),  m_done ? 32'(m_cout) : 32'd0);
      chk("res_ovf",   32'(bus.res_ovf),   m_done ? 32'(m_ovf)  : 32'd0);
      chk("res_id",    32'(bus.res_id),    m_done ? 32'(m_id)   : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op, check latency and literal results. With keep=1 the result
  // is left un-handshaken (caller controls res_ready).
  task automatic run_op(input bit id, input logic [W-1:0] a, b, input bit sub,
                        input logic [W-1:0] es, input bit ec, eo, input bit keep);
    bit got;
    int n;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; end
    else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin got = 1'b1; break; end
    end
    chk("accept_seen", 32'(got), 32'd1);
    tick();
    // Operands change after acceptance; they must not affect the result.
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); bus.req0_sub = 1'($urandom);
    bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); bus.req1_sub = 1'($urandom);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.res_valid) break;
    end
    // First negedge after the accept edge is n=1; valid rises NIBBLES edges later.
    chk("latency",   32'(n), NIBBLES + 1);
    chk("lit_sum",   32'(bus.res_sum),  32'(es));
    chk("lit_cout",  32'(bus.res_cout), 32'(ec));
    chk("lit_ovf",   32'(bus.res_ovf),  32'(eo));
    chk("lit_id",    32'(bus.res_id),   32'(id));
    chk("model_sum", 32'(m_sum), 32'(es));
    if (!keep) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] cap_sum;
    logic         cap_c, cap_o, cap_i;
    int           ids[4];
    int           ng, last_g, cyc;
    bit           prev_hs;

    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_sub = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_sub = 0;
    bus.res_ready = 1'b1;

    // Reset
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_ready0", 32'(bus.req0_ready), 0);
    tick();
    rst_n = 1'b1;

    // Basic vectors
    run_op(0, 16'h1234, 16'h0FDC, 0, 16'h2210, 0, 0, 0);
    run_op(1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0, 0);
    run_op(1, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
    run_op(1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
    run_op(0, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 0);
    run_op(0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0, 0);

    // Hold in DONE with res_ready low while both requesters are pending
    bus.res_ready = 1'b0;
    run_op(0, 16'hA5A5, 16'h5A5B, 0, 16'h0000, 1, 0, 1);
    cap_sum = bus.res_sum; cap_c = bus.res_cout; cap_o = bus.res_ovf; cap_i = bus.res_id;
    tick();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_sum",  32'(bus.res_sum), 32'(cap_sum));
      chk("hold_flags", 32'({bus.res_valid, bus.res_cout, bus.res_ovf, bus.res_id}),
          32'({1'b1, cap_c, cap_o, cap_i}));
      chk("hold_readys", 32'({bus.req0_ready, bus.req1_ready}), 0);
    end
    tick();
    bus.res_ready = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("hold_last_valid", 32'(bus.res_valid), 1);
    tick();
    @(negedge clk);
    chk("hold_cleared", 32'({bus.res_valid, bus.res_sum}), 0);
    tick();

    // Round-robin after reset with both requesters always pending
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0002; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0010; bus.req1_b = 16'h0003; bus.req1_sub = 1'b1;
    ng = 0; last_g = 0; cyc = 0; prev_hs = 1'b0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.req0_ready || bus.req1_ready) begin
        ids[ng] = bus.req1_ready ? 1 : 0;
        if (ng > 0) begin
          chk("rr_gap", 32'(cyc - last_g), NIBBLES + 2);
          chk("rr_after_hs", 32'(prev_hs), 1);
        end
        last_g = cyc;
        ng++;
      end
      prev_hs = bus.res_valid && bus.res_ready;
    end
    chk("rr_count", 32'(ng), 4);
    if (ng == 4) begin
      chk("rr_id0", 32'(ids[0]), 0);
      chk("rr_id1", 32'(ids[1]), 1);
      chk("rr_id2", 32'(ids[2]), 0);
      chk("rr_id3", 32'(ids[3]), 1);
    end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (8) tick();

    // Reset in the middle of RUN after a requester-0 grant
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req0_ready) break;
    end
    tick();                      // accepted; RUN nibble 0
    bus.req0_valid = 1'b0;
    tick();                      // nibble 1
    tick();                      // nibble 2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(bus.res_valid), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(bus.res_valid), 0);
    end
    tick();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("abort_tie_gnt", 32'({bus.req0_ready, bus.req1_ready}), 32'h2);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cla_add_sched.md
CLA_ADD_SCHED -- requirements
Module: cla_add_sched

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  block accepts requester 0 this cycle.
REQ-006 req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 req0_sub  input  1  requester 0 op: 0 = a+b, 1 = a-b.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions, widths and meanings as REQ-004..007, for requester 1.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer takes the result.
REQ-011 res_sum  output  W  result.
REQ-012 res_cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
REQ-013 res_ovf  output  1  two's-complement signed overflow.
REQ-014 res_id  output  1  index of the requester that issued the result.

Function
REQ-015 The block SHALL time-share one internal combinational 4-bit carry-lookahead nibble adder (a[3:0], b[3:0], cin -> sum[3:0], cout) and SHALL NOT instantiate any wider adder.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: if no valid is high, the block stays in IDLE with both readys low.
REQ-018 IDLE arbitration: with one valid, that requester is granted; with both valid, the requester not granted last is granted (round-robin).
REQ-019 Only the granted requester's ready SHALL be high, and only in IDLE; readys are combinational from state, valids and the pointer.
REQ-020 Acceptance edge (valid & ready): the block latches a; latches b, or ~b when sub=1; sets carry = sub; sets the nibble counter to 0; records the id; updates the last-grant pointer; goes to RUN.
REQ-021 RUN: each cycle the block adds nibble k of latched a and b' with the carry register, writes nibble k of the sum register, updates carry, and increments k.
REQ-022 After nibble NIBBLES-1 the block SHALL go to DONE.
REQ-023 Latency: res_valid SHALL rise NIBBLES cycles after the acceptance edge.
REQ-024 DONE: res_valid = 1, and res_sum/res_cout/res_ovf/res_id SHALL stay stable until the edge where res_ready = 1; on that edge the block goes to IDLE.
REQ-025 No new acceptance in RUN or DONE; the earliest next acceptance is the cycle after the result handshake.
REQ-026 res_cout = final carry register; res_ovf = (a[W-1] == b'[W-1]) & (res_sum[W-1] != a[W-1]), with b' = post-inversion operand.
REQ-027 Results wrap modulo 2^W.
REQ-028 Requester inputs are sampled only on the acceptance edge; changes at other times SHALL have no effect.
REQ-029 res_sum, res_cout, res_ovf and res_id SHALL read 0 whenever res_valid = 0.

Reset
REQ-030 While rst_n = 0 at a rising edge, the next state SHALL be: IDLE, counter 0, carry 0, sum register 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-031 Reset SHALL take effect from any state, including mid-RUN and DONE; any in-flight operation is discarded and no res_valid is produced for it.
REQ-032 During and in the cycle after reset, req0_ready, req1_ready and res_valid SHALL be 0 unless REQ-019 grants in the post-reset IDLE cycle.

Verification
REQ-033 req0 a=0x1234, b=0x0FDC, sub=0 -> after 4 cycles res_sum=0x2210, cout=0, ovf=0, id=0.
REQ-034 req1 a=0x0005, b=0x0007, sub=1 -> res_sum=0xFFFE, cout=0, ovf=0, id=1; and a=0x7FFF + 0x0001 -> 0x8000, ovf=1, cout=0; and 0xFFFF + 0x0001 -> 0x0000, cout=1, ovf=0.
REQ-035 After reset, both valids held high with res_ready=1 -> grants in order id 0,1,0,1, and each accept occurs the cycle after the previous result handshake.
REQ-036 res_ready held low 3 cycles in DONE -> outputs unchanged and readys low throughout; result clears and IDLE is entered on the edge where res_ready=1.
REQ-037 rst_n low for one edge at RUN nibble 2 -> next cycle IDLE, res_valid=0, no result emitted; a following tie grants requester 0.
